pwm_sample_dac: RTL and testbench

PWM_SAMPLE_DAC -- requirements
Module: pwm_sample_dac

---
 rtl/pwm_sample_dac_if.sv | 8 +
 rtl/pwm_sample_dac.sv | 137 +++++++++++++
 tb/tb_pwm_sample_dac.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/pwm_sample_dac_if.sv
// Sample stream into the PWM DAC: 12-bit signed sample plus one-cycle valid strobe.
interface pwm_sample_dac_if;
    logic [11:0] sample;
    logic        sample_valid;

    modport master (output sample, output sample_valid);
    modport slave  (input  sample, input  sample_valid);
endinterface

// File: rtl/pwm_sample_dac.sv
// FIFO-buffered 12-bit PWM audio DAC with IDLE/PRIME/RUN sequencing.
// Define PWM_DAC_MIDSCALE_HOLD_EN to load mid-scale duty on underflow.
module pwm_sample_dac #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    pwm_sample_dac_if.slave          s_if,
    input  logic                     enable,
    input  logic                     clear_flags,
    output logic                     pwm_out,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

    state_t        state;
    logic [11:0]   counter;
    logic [11:0]   duty;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [11:0]   mem [DEPTH];

    logic          full;
    logic          empty;
    logic          wrap;
    logic          prime_go;
    logic          push_req;
    logic          push;
    logic          pop;
    logic          ovf_set;
    logic          unf_set;
    logic [11:0]   head;

    assign full     = fifo_level == LW'(DEPTH);
    assign empty    = fifo_level == '0;
    assign wrap     = counter == 12'hFFF;
    assign prime_go = (state == PRIME) && (fifo_level >= LW'(DEPTH / 2));
    assign head     = mem[rd_ptr];

    assign pop      = enable && (prime_go || ((state == RUN) && wrap && !empty));
    assign push_req = enable && s_if.sample_valid && (state != IDLE);
    // A full FIFO still takes the sample when a pop frees a slot this cycle.
    assign push     = push_req && (!full || pop);
    assign ovf_set  = push_req && full && !pop;
    assign unf_set  = enable && (state == RUN) && wrap && empty;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {~s_if.sample[11], s_if.sample[10:0]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            counter    <= '0;
            duty       <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            pwm_out    <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            // Set events take priority over a coincident clear.
            if (ovf_set)
                overflow <= 1'b1;
            else if (clear_flags)
                overflow <= 1'b0;

            if (unf_set)
                underflow <= 1'b1;
            else if (clear_flags)
                underflow <= 1'b0;

            if (!enable) begin
                state      <= IDLE;
                counter    <= '0;
                duty       <= '0;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fifo_level <= '0;
                pwm_out    <= 1'b0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + AW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);

                unique case ({push, pop})
                    2'b10:   fifo_level <= fifo_level + LW'(1);
                    2'b01:   fifo_level <= fifo_level - LW'(1);
                    default: fifo_level <= fifo_level;
                endcase

                unique case (state)
                    IDLE: begin
                        state   <= PRIME;
                        counter <= '0;
                        duty    <= '0;
                        pwm_out <= 1'b0;
                    end
                    PRIME: begin
                        pwm_out <= 1'b0;
                        if (prime_go) begin
                            duty    <= head;
                            counter <= '0;
                            state   <= RUN;
                        end
                    end
                    RUN: begin
                        counter <= counter + 12'd1;
                        pwm_out <= counter < duty;
                        if (wrap) begin
                            if (!empty)
                                duty <= head;
`ifdef PWM_DAC_MIDSCALE_HOLD_EN
                            else
                                duty <= 12'h800;
`endif
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        pwm_out <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_sample_dac.sv
// Directed bench for pwm_sample_dac (DEPTH=4): priming, duty periods, flags, stop, reset.
module tb_pwm_sample_dac;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b0;
    logic       clear_flags = 1'b0;
    logic       pwm_out;
    logic [2:0] fifo_level;
    logic       overflow;
    logic       underflow;

    pwm_sample_dac_if s_if ();

    pwm_sample_dac #(.DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .s_if        (s_if),
        .enable      (enable),
        .clear_flags (clear_flags),
        .pwm_out     (pwm_out),
        .fifo_level  (fifo_level),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;
    int ph     = 0;
    int highs  = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock; ph mirrors the DUT counter once RUN is entered.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        ph = (ph + 1) % 4096;
        if (pwm_out === 1'b1)
            highs++;
    endtask

    task automatic run_to(input int t);
        while (ph != t)
            step();
    endtask

    int exp_h [5] = '{2304, 2560, 2816, 3072, 3584};
    int exp_l [5] = '{4, 3, 2, 1, 0};
    int w;

    initial begin
        s_if.sample       = '0;
        s_if.sample_valid = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_pwm", 32'(pwm_out), 0);
        chk("rst_lvl", 32'(fifo_level), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_unf", 32'(underflow), 0);

        rst = 1'b1;
        step();
        chk("idle_pwm", 32'(pwm_out), 0);
        chk("idle_lvl", 32'(fifo_level), 0);

        enable = 1'b1;
        step();
        s_if.sample_valid = 1'b1;
        s_if.sample = 12'h000;
        step();
        s_if.sample = 12'h7FF;
        step();
        s_if.sample_valid = 1'b0;
        chk("prime_lvl", 32'(fifo_level), 2);
        step();
        chk("prime_pop_lvl", 32'(fifo_level), 1);
        chk("run0_pwm", 32'(pwm_out), 0);

        ph = 0;
        highs = 0;
        repeat (4096) step();
        chk("p1_highs", 32'(highs), 2048);
        chk("p1_end_lvl", 32'(fifo_level), 0);
        highs = 0;

        for (int i = 1; i <= 5; i++) begin
            s_if.sample_valid = 1'b1;
            s_if.sample = 12'(i * 256);
            step();
        end
        s_if.sample_valid = 1'b0;
        chk("ovf_lvl", 32'(fifo_level), 4);
        chk("ovf_set", 32'(overflow), 1);
        clear_flags = 1'b1;
        step();
        clear_flags = 1'b0;
        chk("ovf_clr", 32'(overflow), 0);

        run_to(4095);
        s_if.sample_valid = 1'b1;
        s_if.sample = 12'h600;
        step();
        s_if.sample_valid = 1'b0;
        chk("p2_highs", 32'(highs), 4095);
        chk("wrap_push_lvl", 32'(fifo_level), 4);
        chk("wrap_push_ovf", 32'(overflow), 0);
        highs = 0;

        for (int k = 0; k < 5; k++) begin
            chk($sformatf("p%0d_lvl", k + 3), 32'(fifo_level), 32'(exp_l[k]));
            chk($sformatf("p%0d_unf", k + 3), 32'(underflow), 0);
            repeat (4096) step();
            chk($sformatf("p%0d_highs", k + 3), 32'(highs), 32'(exp_h[k]));
            highs = 0;
        end

        chk("unf_set", 32'(underflow), 1);
        chk("unf_lvl", 32'(fifo_level), 0);
        run_to(5);
        clear_flags = 1'b1;
        step();
        clear_flags = 1'b0;
        chk("unf_clr", 32'(underflow), 0);
        run_to(4095);
        clear_flags = 1'b1;
        step();
        clear_flags = 1'b0;
        chk("unf_set_wins", 32'(underflow), 1);
`ifdef PWM_DAC_MIDSCALE_HOLD_EN
        chk("p8_highs", 32'(highs), 2048);
`else
        chk("p8_highs", 32'(highs), 3584);
`endif
        highs = 0;

        run_to(10);
        s_if.sample_valid = 1'b1;
        s_if.sample = 12'h123;
        step();
        s_if.sample_valid = 1'b0;
        chk("stop_pre_lvl", 32'(fifo_level), 1);
        run_to(1000);
        chk("stop_pre_pwm", 32'(pwm_out), 1);
        enable = 1'b0;
        s_if.sample_valid = 1'b1;
        step();
        s_if.sample_valid = 1'b0;
        chk("stop_pwm", 32'(pwm_out), 0);
        chk("stop_lvl", 32'(fifo_level), 0);
        chk("stop_ovf", 32'(overflow), 0);
        step();
        chk("stop_idle_pwm", 32'(pwm_out), 0);

        enable = 1'b1;
        step();
        s_if.sample_valid = 1'b1;
        s_if.sample = 12'h7FF;
        step();
        s_if.sample = 12'h000;
        step();
        s_if.sample_valid = 1'b0;
        w = 0;
        while (pwm_out !== 1'b1 && w < 8) begin
            step();
            w++;
        end
        chk("rerun_pwm", 32'(pwm_out), 1);
        chk("rerun_lvl", 32'(fifo_level), 1);

        #2 rst = 1'b0;
        #1;
        chk("ares_pwm", 32'(pwm_out), 0);
        chk("ares_lvl", 32'(fifo_level), 0);
        chk("ares_unf", 32'(underflow), 0);
        @(negedge clk);
        rst = 1'b1;
        step();
        chk("post_rst_pwm", 32'(pwm_out), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
